led_shifter_top: RTL and testbench



---
 rtl/led_shifter_pkg.sv | 27 ++
 rtl/led_shifter_if.sv | 26 ++
 rtl/led_shifter_tick_counter.sv | 50 +++++
 rtl/led_shifter_top.sv | 62 ++++++
 tb/tb_led_shifter_top.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/led_shifter_pkg.sv
// Shared encodings for the LED sequencer: switch bit positions, speed and colour codes.
// Default prescaler limits live here so the top and the tick counter agree.
package led_shifter_pkg;

  localparam int SW_EN       = 0;
  localparam int SW_SPEED_LO = 1;
  localparam int SW_SPEED_HI = 2;
  localparam int SW_COLOR    = 3;

  localparam int LIMIT_R0_DEF = 255;
  localparam int LIMIT_R1_DEF = 127;
  localparam int LIMIT_R2_DEF = 63;
  localparam int LIMIT_R3_DEF = 31;

  typedef enum logic [1:0] {
    SPEED_R0 = 2'd0,
    SPEED_R1 = 2'd1,
    SPEED_R2 = 2'd2,
    SPEED_R3 = 2'd3
  } speed_e;

  typedef enum logic {
    COLOR_BLUE  = 1'b0,
    COLOR_GREEN = 1'b1
  } color_e;

endpackage

// File: rtl/led_shifter_if.sv
// Switch inputs and LED outputs of the sequencer bundled as one port.
interface led_shifter_if #(
  parameter int NB_SW   = 4,
  parameter int NB_LEDS = 4
);

  logic [NB_SW-1:0]   i_sw;
  logic [NB_LEDS-1:0] o_led;
  logic [NB_LEDS-1:0] o_led_b;
  logic [NB_LEDS-1:0] o_led_g;

  modport master (
    output i_sw,
    input  o_led,
    input  o_led_b,
    input  o_led_g
  );

  modport slave (
    input  i_sw,
    output o_led,
    output o_led_b,
    output o_led_g
  );

endinterface

// File: rtl/led_shifter_tick_counter.sv
// Prescaler: counts enabled cycles up to the selected limit and flags the wrap cycle.
// tick is combinational from the held count, so it is valid in the cycle the rotate happens.
module led_tick_counter
  import led_shifter_pkg::*;
#(
  parameter int NB_COUNTER = 16,
  parameter int LIMIT_R0   = LIMIT_R0_DEF,
  parameter int LIMIT_R1   = LIMIT_R1_DEF,
  parameter int LIMIT_R2   = LIMIT_R2_DEF,
  parameter int LIMIT_R3   = LIMIT_R3_DEF
) (
  input  logic   clock,
  input  logic   i_reset,
  input  logic   enable,
  input  speed_e speed,
  output logic   tick
);

  logic [NB_COUNTER-1:0] count;
  logic [NB_COUNTER-1:0] limit;
  logic                  at_limit;

  always_comb begin
    limit = NB_COUNTER'(LIMIT_R0);
    unique case (speed)
      SPEED_R0: limit = NB_COUNTER'(LIMIT_R0);
      SPEED_R1: limit = NB_COUNTER'(LIMIT_R1);
      SPEED_R2: limit = NB_COUNTER'(LIMIT_R2);
      SPEED_R3: limit = NB_COUNTER'(LIMIT_R3);
      default:  limit = NB_COUNTER'(LIMIT_R0);
    endcase
  end

  // >= rather than == so a count left above a newly lowered limit wraps at once.
  assign at_limit = (count >= limit);
  assign tick     = enable & at_limit;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (enable) begin
      if (at_limit) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_shifter_top.sv
// LED sequencer: rotates a one-hot pattern on each prescaler tick and steers it to blue or green.
module led_shifter_top
  import led_shifter_pkg::*;
#(
  parameter int NB_LEDS    = 4,
  parameter int NB_COUNTER = 16,
  parameter int NB_SW      = 4,
  parameter int LIMIT_R0   = LIMIT_R0_DEF,
  parameter int LIMIT_R1   = LIMIT_R1_DEF,
  parameter int LIMIT_R2   = LIMIT_R2_DEF,
  parameter int LIMIT_R3   = LIMIT_R3_DEF
) (
  input  logic         clock,
  input  logic         i_reset,
  led_shifter_if.slave bus
);

  logic               enable;
  speed_e             speed;
  color_e             color;
  logic               tick;
  logic [NB_LEDS-1:0] pattern;

  assign enable = bus.i_sw[SW_EN];
  assign speed  = speed_e'(bus.i_sw[SW_SPEED_HI:SW_SPEED_LO]);
  assign color  = color_e'(bus.i_sw[SW_COLOR]);

  led_tick_counter #(
    .NB_COUNTER (NB_COUNTER),
    .LIMIT_R0   (LIMIT_R0),
    .LIMIT_R1   (LIMIT_R1),
    .LIMIT_R2   (LIMIT_R2),
    .LIMIT_R3   (LIMIT_R3)
  ) u_tick (
    .clock   (clock),
    .i_reset (i_reset),
    .enable  (enable),
    .speed   (speed),
    .tick    (tick)
  );

  // Reset seeds a single bit; rotation preserves the one-hot property from then on.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      pattern <= NB_LEDS'(1);
    end else if (tick) begin
      pattern <= {pattern[NB_LEDS-2:0], pattern[NB_LEDS-1]};
    end
  end

  always_comb begin
    bus.o_led   = pattern;
    bus.o_led_b = '0;
    bus.o_led_g = '0;
    if (color == COLOR_GREEN) begin
      bus.o_led_g = pattern;
    end else begin
      bus.o_led_b = pattern;
    end
  end

endmodule

// File: tb/tb_led_shifter_top.sv
// Directed bench for led_shifter_top: vector table plus hand sequences for reset, speed and gating.
module tb_led_shifter_top;

  logic clock = 1'b0;
  logic i_reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  led_shifter_if #(.NB_SW(4), .NB_LEDS(4)) bus ();

  led_shifter_top dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] sw;
    int         cycles;
    logic [3:0] led;
    logic [3:0] led_b;
    logic [3:0] led_g;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [3:0] e_led,
                       input logic [3:0] e_b, input logic [3:0] e_g);
    checks++;
    if (bus.o_led !== e_led || bus.o_led_b !== e_b || bus.o_led_g !== e_g) begin
      errors++;
      $display("FAIL %s: got led=%b b=%b g=%b, required led=%b b=%b g=%b",
               name, bus.o_led, bus.o_led_b, bus.o_led_g, e_led, e_b, e_g);
    end
  endtask

  // Expected colour outputs follow from the colour switch currently driven.
  task automatic check_led(input string name, input logic [3:0] e_led);
    if (bus.i_sw[3]) check(name, e_led, 4'b0000, e_led);
    else             check(name, e_led, e_led, 4'b0000);
  endtask

  // Called at a falling edge; returns at the falling edge after n rising edges.
  task automatic run(input logic [3:0] sw, input int n);
    bus.i_sw = sw;
    if (n == 0) begin
      #1;
    end else begin
      repeat (n) @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic measure(input string name, input logic [3:0] sw, input int exp_int);
    logic [3:0] prev;
    int last = -1;
    int nint = 0;
    int bad = 0;
    int bad_val = 0;
    int shape_bad = 0;
    bus.i_sw = sw;
    prev = bus.o_led;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clock);
      if ($countones(bus.o_led) != 1 ||
          (sw[3] ? (bus.o_led_g !== bus.o_led || bus.o_led_b !== 4'b0000)
                 : (bus.o_led_b !== bus.o_led || bus.o_led_g !== 4'b0000)))
        shape_bad++;
      if (bus.o_led !== prev) begin
        if (last >= 0) begin
          nint++;
          if (c - last != exp_int) begin
            bad++;
            bad_val = c - last;
          end
        end
        last = c;
        prev = bus.o_led;
      end
    end
    checks++;
    if (bad != 0 || nint < 2) begin
      errors++;
      $display("FAIL %s: %0d intervals seen, %0d wrong (last wrong %0d), required all %0d",
               name, nint, bad, bad_val, exp_int);
    end
    checks++;
    if (shape_bad != 0) begin
      errors++;
      $display("FAIL %s_onehot: %0d bad cycles, required 0", name, shape_bad);
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 255, 4'b0001, 4'b0001, 4'b0000};
    vecs[1]  = '{4'b0001,   1, 4'b0010, 4'b0010, 4'b0000};
    vecs[2]  = '{4'b0001, 256, 4'b0100, 4'b0100, 4'b0000};
    vecs[3]  = '{4'b0001, 256, 4'b1000, 4'b1000, 4'b0000};
    vecs[4]  = '{4'b0001, 256, 4'b0001, 4'b0001, 4'b0000};
    vecs[5]  = '{4'b1001,   0, 4'b0001, 4'b0000, 4'b0001};
    vecs[6]  = '{4'b1001, 100, 4'b0001, 4'b0000, 4'b0001};
    vecs[7]  = '{4'b0001,   0, 4'b0001, 4'b0001, 4'b0000};
    vecs[8]  = '{4'b0000, 100, 4'b0001, 4'b0001, 4'b0000};
    vecs[9]  = '{4'b0001, 155, 4'b0001, 4'b0001, 4'b0000};
    vecs[10] = '{4'b0001,   1, 4'b0010, 4'b0010, 4'b0000};
    vecs[11] = '{4'b0111,  31, 4'b0010, 4'b0010, 4'b0000};
    vecs[12] = '{4'b0111,   1, 4'b0100, 4'b0100, 4'b0000};
    vecs[13] = '{4'b0111,  32, 4'b1000, 4'b1000, 4'b0000};
    vecs[14] = '{4'b0011, 128, 4'b0001, 4'b0001, 4'b0000};
    vecs[15] = '{4'b0101,  64, 4'b0010, 4'b0010, 4'b0000};
    vecs[16] = '{4'b1101,  64, 4'b0100, 4'b0000, 4'b0100};

    i_reset  = 1'b0;
    bus.i_sw = 4'b0000;
    #2;
    for (int i = 0; i < 10; i++) begin
      #10;
      check($sformatf("reset_hold%0d", i), 4'b0001, 4'b0001, 4'b0000);
    end
    @(negedge clock);
    i_reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run(vecs[i].sw, vecs[i].cycles);
      check($sformatf("vec%0d", i), vecs[i].led, vecs[i].led_b, vecs[i].led_g);
    end

    // Asynchronous reset mid-run at R2, away from any clock edge.
    run(4'b0101, 10);
    check_led("r2_before_reset", 4'b0100);
    @(posedge clock);
    #3 i_reset = 1'b0;
    #1 check_led("reset_async", 4'b0001);
    @(negedge clock);
    i_reset = 1'b1;
    run(4'b0101, 63);
    check_led("post_reset_63", 4'b0001);
    run(4'b0101, 1);
    check_led("post_reset_64", 4'b0010);

    // Count of 200 is above the R3 limit: wraps on the first R3 edge.
    run(4'b0001, 200);
    check_led("r0_count200", 4'b0010);
    run(4'b0111, 1);
    check_led("r0_to_r3_wrap", 4'b0100);

    // Enable gating holds the partial count.
    run(4'b0101, 40);
    check_led("gate_pre", 4'b0100);
    run(4'b0100, 100);
    check_led("gate_frozen", 4'b0100);
    run(4'b0101, 23);
    check_led("gate_resume_23", 4'b0100);
    run(4'b0101, 1);
    check_led("gate_resume_24", 4'b1000);

    measure("interval_r1", 4'b0011, 128);
    measure("interval_r2_green", 4'b1101, 64);
    measure("interval_r3", 4'b0111, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
